// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM encoding and default parameters for the bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, OWN, TURN} state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 15;
    localparam int ID_W         = 3;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select of the first set req bit at or after ptr
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  win
);

    logic [ID_W:0]    idx;
    logic [N_REQ-1:0] rot;

    always_comb begin
        any = 1'b0;
        win = '0;
        idx = '0;
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            idx = (idx >= (ID_W+1)'(N_REQ)) ? idx - (ID_W+1)'(N_REQ) : idx;
            rot = req >> idx;
            if (!any && rot[0]) begin
                any = 1'b1;
                win = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with setup/turnaround cycles and hold timeout
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] oe,
    output logic [2:0]       gnt_id,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [N_REQ-1:0] ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]  LAST = ID_W'(N_REQ-1);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] nxt_ptr;
    logic [7:0]      hold;
    logic            any;
    logic            own_done;
    logic            own_req;
    logic            at_max;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (any),
        .win (win)
    );

    // gnt is one-hot at the owner in OWN, so masking with it selects the owner's bits
    assign own_done = |(done & gnt);
    assign own_req  = |(req & gnt);
    assign at_max   = hold == 8'(MAX_HOLD);
    assign nxt_ptr  = (win == LAST) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            hold        <= '0;
            gnt         <= '0;
            oe          <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    hold <= '0;
                    oe   <= '0;
                    if (any) begin
                        state  <= GRANT;
                        rr_ptr <= nxt_ptr;
                        gnt    <= ONE << win;
                        gnt_id <= win;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    state <= OWN;
                    oe    <= gnt;
                    hold  <= 8'd1;
                end
                OWN: begin
                    if (own_done || !own_req || at_max) begin
                        state       <= TURN;
                        gnt         <= '0;
                        oe          <= '0;
                        gnt_id      <= '0;
                        timeout_err <= at_max && !own_done && own_req;
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a grant-event scoreboard and per-cycle invariants
module tb_bus_arbiter;

    typedef struct {
        int   id;
        int   len;
        logic to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic [3:0] oe;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout_err;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .oe          (oe),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(int i);
        return 4'b0001 << i;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(int id, int len, logic to);
        exp_t e;
        e.id = id;
        e.len = len;
        e.to = to;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        done = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_oe", oe, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
    endtask

    task automatic wait_oe(int id);
        int n = 0;
        while (oe != oh(id) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("wait_oe_timeout", oe, oh(id));
    endtask

    // own requester id for k OWN cycles, releasing with done and clearing req bits in clr
    task automatic own_for(int id, int k, logic [3:0] clr);
        wait_oe(id);
        repeat (k - 1) @(negedge clk);
        done = oh(id);
        req = req & ~clr;
        @(negedge clk);
        done = '0;
    endtask

    // scoreboard monitor: every new grant pops one expected ownership and follows it to TURN
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (gnt != 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", gnt, 0);
                    continue;
                end
                e = q.pop_front();
                chk("grant_id", gnt_id, e.id);
                chk("grant_vec", gnt, oh(e.id));
                chk("grant_setup_oe", oe, 0);
                n = 0;
                @(negedge clk);
                while (oe != 0 && n < 300) begin
                    chk("own_oe", oe, oh(e.id));
                    n++;
                    @(negedge clk);
                end
                chk("own_len", n, e.len);
                chk("turn_gnt", gnt, 0);
                chk("turn_timeout", timeout_err, e.to);
            end
        end
    end

    always @(negedge clk) begin
        chk("inv_oe_onehot", $onehot0(oe), 1);
        chk("inv_oe_subset", oe & ~gnt, 0);
        chk("inv_gnt_onehot", $onehot0(gnt), 1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        // single request latency and release to IDLE
        push(0, 1, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        chk("lat_gnt", gnt, 4'b0001);
        chk("lat_oe_setup", oe, 0);
        @(negedge clk);
        chk("lat_oe", oe, 4'b0001);
        done = 4'b0001;
        req = '0;
        @(negedge clk);
        done = '0;
        chk("single_turn_oe", oe, 0);
        chk("single_turn_busy", busy, 1);
        @(negedge clk);
        chk("single_idle_busy", busy, 0);
        chk("single_idle_gnt", gnt, 0);
        // round-robin fairness
        do_reset();
        push(0, 2, 1'b0);
        push(1, 2, 1'b0);
        push(2, 2, 1'b0);
        push(3, 2, 1'b0);
        push(0, 2, 1'b0);
        req = 4'b1111;
        own_for(0, 2, 4'b0000);
        own_for(1, 2, 4'b0000);
        own_for(2, 2, 4'b0000);
        own_for(3, 2, 4'b0000);
        own_for(0, 2, 4'b1111);
        repeat (2) @(negedge clk);
        // timeout with non-owner done ignored, then re-grant to 2
        do_reset();
        push(2, 15, 1'b1);
        push(2, 1, 1'b0);
        req = 4'b0100;
        wait_oe(2);
        done = 4'b1011;
        @(negedge clk);
        done = '0;
        n = 0;
        while (oe != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("timeout_single_pulse", timeout_err, 0);
        chk("timeout_regrant", gnt, 4'b0100);
        own_for(2, 1, 4'b1111);
        repeat (2) @(negedge clk);
        // wrap priority: pointer at 3 after owner 2
        do_reset();
        push(2, 1, 1'b0);
        req = 4'b0100;
        own_for(2, 1, 4'b0100);
        @(negedge clk);
        push(0, 1, 1'b0);
        req = 4'b0101;
        own_for(0, 1, 4'b1111);
        repeat (2) @(negedge clk);
        // reset in the middle of ownership
        do_reset();
        push(1, 2, 1'b0);
        req = 4'b0010;
        wait_oe(1);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("midrst_oe", oe, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_timeout", timeout_err, 0);
        push(0, 1, 1'b0);
        push(1, 1, 1'b0);
        req = 4'b0011;
        rst_n = 1'b1;
        own_for(0, 1, 4'b0001);
        own_for(1, 1, 4'b0010);
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of bus requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 15, is the maximum ownership cycles before a forced release (1..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  N_REQ  per-requester bus request, level, held until done or granted-and-finished.
REQ-006 done  input  N_REQ  per-requester release strobe, sampled only for current owner.
REQ-007 gnt  output  N_REQ  one-hot grant (all-zero when no owner).
REQ-008 oe  output  N_REQ  one-hot tri-state drive enable for shared bus1; subset of gnt.
REQ-009 gnt_id  output  3  binary index of current owner; 0 when none.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 FSM states: IDLE, GRANT, OWN, TURN; encoding from shared package.
REQ-013 IDLE: if any req bit high, pick winner by round-robin starting at pointer rr_ptr, go to GRANT; else stay.
REQ-014 Round-robin: winner = first set req bit at index rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ; on entering GRANT rr_ptr := winner+1 mod N_REQ.
REQ-015 GRANT (exactly 1 cycle): gnt one-hot at winner, oe all-zero (setup cycle), then OWN.
REQ-016 OWN: gnt and oe both one-hot at owner; hold counter increments each OWN cycle starting at 1.
REQ-017 OWN exit to TURN when done[owner]=1, or req[owner]=0, or hold counter = MAX_HOLD; the exit cycle still drives oe.
REQ-018 Forced exit (counter = MAX_HOLD without done[owner] or req drop) pulses timeout_err in the first TURN cycle.
REQ-019 done or req on non-owner bits during OWN are ignored and do not affect ownership.
REQ-020 TURN (exactly 1 cycle): gnt and oe all-zero (bus turnaround, no driver); then GRANT to new winner if any req high, else IDLE.
REQ-021 In TURN, arbitration uses updated rr_ptr, so the previous owner has lowest priority when others request.
REQ-022 Grant latency from req rising in IDLE: gnt high 1 cycle later, oe high 2 cycles later.
REQ-023 At most one oe bit high in any cycle; oe never high in GRANT, TURN or IDLE.
REQ-024 A request withdrawn during GRANT: the FSM still enters OWN, then exits to TURN on the next cycle via REQ-017.

Reset
REQ-025 While rst_n=0 at a clock edge: state:=IDLE, rr_ptr:=0, hold counter:=0, gnt=0, oe=0, gnt_id=0, busy=0, timeout_err=0.
REQ-026 Reset asserted mid-ownership drops oe and gnt at that edge with no TURN cycle and no timeout_err.

Structure
REQ-027 State enum and default parameter constants belong in package bus_arb_pkg.
REQ-028 One sub-module, rr_picker (combinational round-robin priority select given req and rr_ptr), is natural; the rest is one module.
REQ-029 All outputs are registered.

Verification
REQ-030 Single request: reset, req=0001 -> gnt=0001 next cycle, oe=0001 the cycle after; done[0] -> TURN with oe=0, then IDLE, busy=0.
REQ-031 Round-robin fairness: req=1111 held, each owner pulses done after 2 OWN cycles -> grant order 0,1,2,3,0, with one TURN cycle between owners.
REQ-032 Timeout: req=0100 held, no done, MAX_HOLD=15 -> exactly 15 OWN cycles with oe=0100, then timeout_err pulses once in TURN, then re-grant to 2.
REQ-033 Wrap priority: rr_ptr=3 after owner 2, req=0101 -> winner 0; gnt_id=0.
REQ-034 Reset mid-OWN: owner 1 in OWN, rst_n=0 one cycle -> oe=0, gnt=0, rr_ptr=0 at that edge; with req=0011 after release, winner 0.
REQ-035 Invariant check every cycle: oe one-hot or zero, oe is a subset of gnt, no oe in GRANT or TURN.
